// File: rtl/counter_chk_pkg.sv
// counter_chk_pkg: shared definitions for the counter sequence checker.
//   - chk_state_e : checker state (2-bit encoding)
//   - DEF_*       : default parameter values for an observed 0..7 counter
//   - MODE_UP / MODE_DOWN : direction encoding of the observed mode signal
package counter_chk_pkg;

  localparam int unsigned DEF_WIDTH  = 3;
  localparam int unsigned DEF_MAX    = 7;
  localparam int unsigned DEF_LOCK_N = 2;
  localparam int unsigned DEF_ERR_W  = 8;

  localparam logic MODE_UP   = 1'b1;
  localparam logic MODE_DOWN = 1'b0;

  typedef enum logic [1:0] {
    StSync   = 2'd0,
    StHunt   = 2'd1,
    StLocked = 2'd2
  } chk_state_e;

endpackage

// File: rtl/cnt_step.sv
// cnt_step: combinational next value of a bounded modulo up/down counter.
// Ports:
//   q_i    - current value (assumed 0..MAX)
//   mode_i - direction, MODE_UP or MODE_DOWN
//   next_o - value the counter takes on its next step
module cnt_step
  import counter_chk_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned MAX   = DEF_MAX
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] next_o
);

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX);

  always_comb begin
    next_o = q_i;
    unique case (mode_i)
      MODE_UP:   next_o = (q_i == MaxV) ? '0 : q_i + WIDTH'(1);
      MODE_DOWN: next_o = (q_i == '0) ? MaxV : q_i - WIDTH'(1);
      default:   next_o = q_i;
    endcase
  end

endmodule

// File: rtl/counter_seq_checker.sv
// counter_seq_checker: monitors the output stream of a bounded up/down counter,
// predicts each next value from the previous sample and flags deviations.
// Ports:
//   clk       - rising-edge clock shared with the observed counter
//   rst       - asynchronous active-low reset
//   en        - checking enable; 0 suspends checking and forces re-sync
//   q_in      - observed count value
//   mode_in   - observed direction (1 = up, 0 = down)
//   locked    - high while the stream is locked
//   seq_err   - one-cycle pulse on a sequence mismatch while locked
//   range_err - one-cycle pulse on q_in > MAX while enabled
//   wrap      - one-cycle pulse on a legal boundary crossing while locked
//   err_cnt   - saturating count of seq_err events
//   expected  - predicted value of the next sample
// Optional feature (macro CHK_STICKY_ERR_EN):
//   err_clr   - clears err_flag and err_cnt at a clock edge
//   err_flag  - sticky flag set by any seq_err or range_err pulse
// All outputs are registered: flags appear one cycle after the sampling edge.
module counter_seq_checker
  import counter_chk_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned MAX    = DEF_MAX,
  parameter int unsigned LOCK_N = DEF_LOCK_N,
  parameter int unsigned ERR_W  = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  input  logic             mode_in,
  output logic             locked,
  output logic             seq_err,
  output logic             range_err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] expected
`ifdef CHK_STICKY_ERR_EN
  ,
  input  logic             err_clr,
  output logic             err_flag
`endif
);

  localparam logic [WIDTH-1:0] MaxV   = WIDTH'(MAX);
  localparam int unsigned      CntW   = 4;
  localparam logic [CntW-1:0]  LockV  = CntW'(LOCK_N);
  localparam logic [ERR_W-1:0] ErrSat = '1;

  chk_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_val_q, prev_val_d;
  logic             prev_mode_q, prev_mode_d;
  logic [CntW-1:0]  match_q, match_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             locked_q, seq_err_q, range_err_q, wrap_q;
  logic             seq_err_d, range_err_d, wrap_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] pred;
  logic [WIDTH:0]   range_diff;
  logic             out_of_range, hit, at_bound;

  // Prediction for the current sample, and the value published for the next one.
  cnt_step #(.WIDTH(WIDTH), .MAX(MAX)) u_step_pred (
    .q_i    (prev_val_q),
    .mode_i (prev_mode_q),
    .next_o (pred)
  );

  cnt_step #(.WIDTH(WIDTH), .MAX(MAX)) u_step_next (
    .q_i    (prev_val_d),
    .mode_i (prev_mode_d),
    .next_o (expected_d)
  );

  // Borrow out of MAX - q_in means q_in > MAX; avoids a compare that folds to
  // constant when MAX fills the whole WIDTH range.
  assign range_diff   = {1'b0, MaxV} - {1'b0, q_in};
  assign out_of_range = range_diff[WIDTH];
  assign hit          = (q_in == pred);
  assign at_bound     = (prev_mode_q == MODE_UP) ? (prev_val_q == MaxV) : (prev_val_q == '0);

  always_comb begin
    state_d     = state_q;
    prev_val_d  = prev_val_q;
    prev_mode_d = prev_mode_q;
    match_d     = match_q;
    seq_err_d   = 1'b0;
    range_err_d = 1'b0;
    wrap_d      = 1'b0;

    if (!en) begin
      state_d = StSync;
    end else if (out_of_range) begin
      range_err_d = 1'b1;
      seq_err_d   = (state_q == StLocked);
      state_d     = StSync;
    end else begin
      // Every in-range sample becomes the base of the next prediction; on a
      // hit it equals the prediction anyway, on a miss it is the recapture.
      prev_val_d  = q_in;
      prev_mode_d = mode_in;
      unique case (state_q)
        StSync: begin
          match_d = '0;
          state_d = StHunt;
        end
        StHunt: begin
          if (hit) begin
            match_d = match_q + CntW'(1);
            if (match_d >= LockV) state_d = StLocked;
          end else begin
            match_d = '0;
          end
        end
        StLocked: begin
          if (hit) begin
            wrap_d = at_bound;
          end else begin
            seq_err_d = 1'b1;
            match_d   = '0;
            state_d   = StHunt;
          end
        end
        default: state_d = StSync;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
`ifdef CHK_STICKY_ERR_EN
    if (err_clr) err_cnt_d = '0;
`endif
    // A coincident clear and error leaves a count of one.
    if (seq_err_d && (err_cnt_d != ErrSat)) err_cnt_d = err_cnt_d + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StSync;
      prev_val_q  <= '0;
      prev_mode_q <= 1'b0;
      match_q     <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      range_err_q <= 1'b0;
      wrap_q      <= 1'b0;
      expected_q  <= '0;
    end else begin
      state_q     <= state_d;
      prev_val_q  <= prev_val_d;
      prev_mode_q <= prev_mode_d;
      match_q     <= match_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= (state_d == StLocked);
      seq_err_q   <= seq_err_d;
      range_err_q <= range_err_d;
      wrap_q      <= wrap_d;
      expected_q  <= expected_d;
    end
  end

`ifdef CHK_STICKY_ERR_EN
  logic err_flag_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag_q <= 1'b0;
    end else if (seq_err_d || range_err_d) begin
      err_flag_q <= 1'b1;
    end else if (err_clr) begin
      err_flag_q <= 1'b0;
    end
  end

  assign err_flag = err_flag_q;
`endif

  assign locked    = locked_q;
  assign seq_err   = seq_err_q;
  assign range_err = range_err_q;
  assign wrap      = wrap_q;
  assign err_cnt   = err_cnt_q;
  assign expected  = expected_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: two instances (0..7 on 3 bits, 0..9 on 4 bits)
// share enable/mode/clear and are compared every cycle against a behavioural
// model built from modulo arithmetic.
module tb_counter_seq_checker;

  localparam int LockN = 2;
  localparam int ErrMax = 255;
  localparam int SSync = 0;
  localparam int SHunt = 1;
  localparam int SLocked = 2;

  typedef struct packed {
    int st;
    int pq;
    bit pm;
    int mc;
    int errc;
    bit flag;
    bit locked;
    bit seq;
    bit rng;
    bit wrap;
    int expv;
  } mdl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       err_clr = 1'b0;
  logic [2:0] q_a = '0;
  logic [3:0] q_b = '0;

  logic       locked_a, seq_err_a, range_err_a, wrap_a;
  logic [7:0] err_cnt_a;
  logic [2:0] expected_a;
  logic       locked_b, seq_err_b, range_err_b, wrap_b;
  logic [7:0] err_cnt_b;
  logic [3:0] expected_b;
`ifdef CHK_STICKY_ERR_EN
  logic       err_flag_a, err_flag_b;
`endif

  int   n_chk = 0;
  int   n_err = 0;
  mdl_t ma = '0;
  mdl_t mb = '0;

  always #5 clk = ~clk;

  counter_seq_checker #(.WIDTH(3), .MAX(7), .LOCK_N(LockN), .ERR_W(8)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .q_in      (q_a),
    .mode_in   (mode),
    .locked    (locked_a),
    .seq_err   (seq_err_a),
    .range_err (range_err_a),
    .wrap      (wrap_a),
    .err_cnt   (err_cnt_a),
    .expected  (expected_a)
`ifdef CHK_STICKY_ERR_EN
    ,
    .err_clr   (err_clr),
    .err_flag  (err_flag_a)
`endif
  );

  counter_seq_checker #(.WIDTH(4), .MAX(9), .LOCK_N(LockN), .ERR_W(8)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .q_in      (q_b),
    .mode_in   (mode),
    .locked    (locked_b),
    .seq_err   (seq_err_b),
    .range_err (range_err_b),
    .wrap      (wrap_b),
    .err_cnt   (err_cnt_b),
    .expected  (expected_b)
`ifdef CHK_STICKY_ERR_EN
    ,
    .err_clr   (err_clr),
    .err_flag  (err_flag_b)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, want %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int succ(input int v, input bit up, input int max);
    return up ? (v + 1) % (max + 1) : (v + max) % (max + 1);
  endfunction

  // One sampling edge of the checker as described by its rules.
  function automatic mdl_t mdl_step(input mdl_t m, input int q, input bit md, input bit e,
                                    input bit clr, input int max);
    mdl_t n;
    bit   hit;
    n     = m;
    n.seq  = 1'b0;
    n.rng  = 1'b0;
    n.wrap = 1'b0;
    hit   = (q == succ(m.pq, m.pm, max));
    if (!e) begin
      n.st = SSync;
    end else if (q > max) begin
      n.rng = 1'b1;
      n.seq = (m.st == SLocked);
      n.st  = SSync;
    end else begin
      n.pq = q;
      n.pm = md;
      if (m.st == SSync) begin
        n.mc = 0;
        n.st = SHunt;
      end else if (m.st == SHunt) begin
        if (hit) begin
          n.mc = m.mc + 1;
          if (n.mc >= LockN) n.st = SLocked;
        end else begin
          n.mc = 0;
        end
      end else if (hit) begin
        // A legal step that goes backwards in its own direction is a wrap.
        n.wrap = m.pm ? (q < m.pq) : (q > m.pq);
      end else begin
        n.seq = 1'b1;
        n.mc  = 0;
        n.st  = SHunt;
      end
    end
    if (clr) n.errc = 0;
    if (n.seq && n.errc < ErrMax) n.errc = n.errc + 1;
    if (n.seq || n.rng) n.flag = 1'b1;
    else if (clr) n.flag = 1'b0;
    n.locked = (n.st == SLocked);
    n.expv   = succ(n.pq, n.pm, max);
    return n;
  endfunction

  task automatic check_all();
    check("a.locked", locked_a, ma.locked);
    check("a.seq_err", seq_err_a, ma.seq);
    check("a.range_err", range_err_a, ma.rng);
    check("a.wrap", wrap_a, ma.wrap);
    check("a.err_cnt", err_cnt_a, ma.errc);
    check("a.expected", expected_a, ma.expv);
    check("b.locked", locked_b, mb.locked);
    check("b.seq_err", seq_err_b, mb.seq);
    check("b.range_err", range_err_b, mb.rng);
    check("b.wrap", wrap_b, mb.wrap);
    check("b.err_cnt", err_cnt_b, mb.errc);
    check("b.expected", expected_b, mb.expv);
`ifdef CHK_STICKY_ERR_EN
    check("a.err_flag", err_flag_a, ma.flag);
    check("b.err_flag", err_flag_b, mb.flag);
`endif
  endtask

  // Called at a falling edge: drive, let the rising edge happen, then compare.
  task automatic cycle(input int qa, input int qb, input bit md, input bit e);
    q_a  = 3'(qa);
    q_b  = 4'(qb);
    mode = md;
    en   = e;
    @(posedge clk);
    ma = mdl_step(ma, int'(q_a), md, e, err_clr, 7);
    mb = mdl_step(mb, int'(q_b), md, e, err_clr, 9);
    @(negedge clk);
    check_all();
  endtask

  task automatic lock_a_from_zero();
    cycle(0, 0, 1'b1, 1'b1);
    cycle(1, 1, 1'b1, 1'b1);
    cycle(2, 2, 1'b1, 1'b1);
    cycle(3, 3, 1'b1, 1'b1);
    check("a.lock_seq", locked_a, 1);
  endtask

  initial begin
    int ca;
    int cb;
    bit md;

    #12;
    check_all();
    check("reset.expected", expected_a, 0);
    rst = 1'b1;
    @(negedge clk);

    // Lock-in: 0,1,2 locks (LOCK_N=2), after 3 the prediction is 4.
    cycle(0, 0, 1'b1, 1'b1);
    cycle(1, 1, 1'b1, 1'b1);
    check("a.not_locked_yet", locked_a, 0);
    cycle(2, 2, 1'b1, 1'b1);
    check("a.locked_3rd", locked_a, 1);
    cycle(3, 3, 1'b1, 1'b1);
    check("a.expected_4", expected_a, 4);
    check("a.no_seq_err", seq_err_a, 0);

    // Up wrap 7 -> 0.
    for (int v = 4; v <= 7; v++) cycle(v, v, 1'b1, 1'b1);
    cycle(0, 0, 1'b1, 1'b1);
    check("a.wrap_pulse", wrap_a, 1);
    cycle(1, 1, 1'b1, 1'b1);
    check("a.wrap_gone", wrap_a, 0);
    check("a.still_locked", locked_a, 1);

    // Mode change honoured one sample late: 2,3 up then 4,3,2,1,0 down.
    cycle(2, 2, 1'b1, 1'b1);
    cycle(3, 3, 1'b1, 1'b1);
    for (int v = 4; v >= 0; v--) begin
      cycle(v, v, 1'b0, 1'b1);
      check("a.mode_lag_ok", seq_err_a, 0);
    end
    cycle(7, 7, 1'b1, 1'b1);
    check("a.down_wrap", wrap_a, 1);
    cycle(0, 0, 1'b1, 1'b1);
    check("a.locked_after_turn", locked_a, 1);

    // Error injection, repeated until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      cycle(1, 1, 1'b1, 1'b1);
      cycle(2, 2, 1'b1, 1'b1);
      cycle(3, 3, 1'b1, 1'b1);
      cycle(5, 5, 1'b1, 1'b1);
      if (i == 0) begin
        check("a.inject_seq_err", seq_err_a, 1);
        check("a.inject_cnt", err_cnt_a, 1);
        check("a.inject_unlock", locked_a, 0);
      end
      cycle(6, 6, 1'b1, 1'b1);
      cycle(7, 7, 1'b1, 1'b1);
      if (i == 0) check("a.relock", locked_a, 1);
      cycle(0, 0, 1'b1, 1'b1);
    end
    check("a.err_saturated", err_cnt_a, 255);

    // Disable: drops lock, holds count.
    for (int i = 0; i < 3; i++) cycle(1, 1, 1'b1, 1'b0);
    check("a.en0_unlocked", locked_a, 0);
    check("a.en0_cnt_held", err_cnt_a, 255);

    // Out-of-range on the 0..9 instance while locked.
    for (int v = 0; v <= 3; v++) cycle(v, v, 1'b1, 1'b1);
    check("b.locked", locked_b, 1);
    cycle(4, 12, 1'b1, 1'b1);
    check("b.range_pulse", range_err_b, 1);
    check("b.range_seq", seq_err_b, 1);
    check("b.range_unlock", locked_b, 0);
    cycle(5, 5, 1'b1, 1'b1);
    check("b.range_gone", range_err_b, 0);

    // Random phase: a drifting counter with glitches, pauses and bad values.
    ca = 0;
    cb = 0;
    md = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      int qa;
      int qb;
      bit e;
      if ($urandom_range(0, 7) == 0) md = ~md;
      ca = succ(ca, md, 7);
      cb = succ(cb, md, 9);
      qa = ca;
      qb = cb;
      if ($urandom_range(0, 19) == 0) qa = int'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) qb = int'($urandom_range(0, 15));
      e = ($urandom_range(0, 29) != 0);
      cycle(qa, qb, md, e);
    end

    // Asynchronous reset while locked.
    lock_a_from_zero();
    #2 rst = 1'b0;
    ma = '0;
    mb = '0;
    #1;
    check_all();
    check("a.rst_locked", locked_a, 0);
    check("a.rst_err_cnt", err_cnt_a, 0);
    #1 rst = 1'b1;
    @(negedge clk);

`ifdef CHK_STICKY_ERR_EN
    lock_a_from_zero();
    cycle(5, 5, 1'b1, 1'b1);
    check("a.flag_set", err_flag_a, 1);
    err_clr = 1'b1;
    cycle(6, 6, 1'b1, 1'b1);
    err_clr = 1'b0;
    check("a.flag_cleared", err_flag_a, 0);
    check("a.cnt_cleared", err_cnt_a, 0);
    cycle(7, 7, 1'b1, 1'b1);
    cycle(0, 0, 1'b1, 1'b1);
    check("a.relocked", locked_a, 1);
    err_clr = 1'b1;
    cycle(2, 2, 1'b1, 1'b1);
    err_clr = 1'b0;
    check("a.clr_vs_err_flag", err_flag_a, 1);
    check("a.clr_vs_err_cnt", err_cnt_a, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
